// File: rtl/decode_stage.sv
// MIPS32 instruction-decode stage: instruction queue, combinational decode of the
// queue head, and a registered decode record handed to EX with a valid/ready handshake.
module decode_stage #(
  parameter int unsigned IQ_DEPTH     = 4,
  parameter bit          EN_MOVCOND   = 1'b1,
  parameter bit          EN_LOADSTORE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  input  logic        ex_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [1:0]  id_instr_type,
  output logic [3:0]  id_aluop,
  output logic [4:0]  id_sa,
  output logic        id_sa_en,
  output logic [31:0] id_ext_imm,
  output logic [4:0]  id_raddr1,
  output logic [4:0]  id_raddr2,
  output logic [4:0]  id_waddr,
  output logic        id_reg_wr,
  output logic        id_mem_rd,
  output logic        id_mem_wr,
  output logic [1:0]  id_cond,
  output logic        id_illegal
);

  localparam int unsigned AW = $clog2(IQ_DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [1:0] TYPE_R = 2'b01, TYPE_I = 2'b10;
  localparam logic [1:0] NO_COND = 2'd0, COND_SRC2_NZ = 2'd1, COND_SRC2_Z = 2'd2;
  localparam logic [3:0] ALU_AND = 4'd0, ALU_OR = 4'd1, ALU_XOR = 4'd2, ALU_NOR = 4'd3,
                         ALU_SLL = 4'd4, ALU_SRL = 4'd5, ALU_SRA = 4'd6, ALU_MOV = 4'd7,
                         ALU_ADD = 4'd8;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_ADDIU = 6'h09, OP_ANDI = 6'h0C,
                         OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F,
                         OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
                         F_SRLV = 6'h06, F_SRAV = 6'h07, F_MOVZ = 6'h0A, F_MOVN = 6'h0B,
                         F_ADDU = 6'h21, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26,
                         F_NOR = 6'h27;

  typedef struct packed {
    logic [1:0]  itype;
    logic [3:0]  aluop;
    logic [4:0]  sa;
    logic        sa_en;
    logic [31:0] ext;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  wa;
    logic        we;
    logic        mr;
    logic        mw;
    logic [1:0]  cond;
    logic        ill;
  } dec_t;

  localparam dec_t DEC_IDLE = '{itype: TYPE_I, aluop: ALU_OR, sa: '0, sa_en: 1'b0, ext: '0,
                                r1: '0, r2: '0, wa: '0, we: 1'b0, mr: 1'b0, mw: 1'b0,
                                cond: NO_COND, ill: 1'b0};

  logic [PW-1:0] wptr, rptr;
  logic [31:0]   mem_pc    [IQ_DEPTH];
  logic [31:0]   mem_instr [IQ_DEPTH];
  logic          empty, full, push, adv, haz, load, bad;
  logic [31:0]   head_pc, head;
  dec_t          d, q;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign if_ready = !full;
  assign push     = if_valid && !full;
  assign head_pc  = mem_pc[rptr[AW-1:0]];
  assign head     = mem_instr[rptr[AW-1:0]];

  always_comb begin
    d   = DEC_IDLE;
    bad = 1'b0;
    case (head[31:26])
      OP_SPECIAL: begin
        d.itype = TYPE_R;
        d.r1    = head[25:21];
        d.r2    = head[20:16];
        d.wa    = head[15:11];
        d.we    = 1'b1;
        case (head[5:0])
          F_SLL:  begin d.aluop = ALU_SLL; d.r1 = '0; d.sa = head[10:6]; d.sa_en = 1'b1; end
          F_SRL:  begin d.aluop = ALU_SRL; d.r1 = '0; d.sa = head[10:6]; d.sa_en = 1'b1; end
          F_SRA:  begin d.aluop = ALU_SRA; d.r1 = '0; d.sa = head[10:6]; d.sa_en = 1'b1; end
          F_SLLV: d.aluop = ALU_SLL;
          F_SRLV: d.aluop = ALU_SRL;
          F_SRAV: d.aluop = ALU_SRA;
          F_MOVZ: if (EN_MOVCOND) begin d.aluop = ALU_MOV; d.cond = COND_SRC2_Z; end else bad = 1'b1;
          F_MOVN: if (EN_MOVCOND) begin d.aluop = ALU_MOV; d.cond = COND_SRC2_NZ; end else bad = 1'b1;
          F_ADDU: d.aluop = ALU_ADD;
          F_AND:  d.aluop = ALU_AND;
          F_OR:   d.aluop = ALU_OR;
          F_XOR:  d.aluop = ALU_XOR;
          F_NOR:  d.aluop = ALU_NOR;
          default: bad = 1'b1;
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        d.aluop = (head[27:26] == 2'b00) ? ALU_AND : (head[27:26] == 2'b01) ? ALU_OR : ALU_XOR;
        d.ext   = {16'h0000, head[15:0]};
        d.r1    = head[25:21];
        d.wa    = head[20:16];
        d.we    = 1'b1;
      end
      OP_LUI: begin
        d.ext = {head[15:0], 16'h0000};
        d.wa  = head[20:16];
        d.we  = 1'b1;
      end
      OP_ADDIU: begin
        d.aluop = ALU_ADD;
        d.ext   = {{16{head[15]}}, head[15:0]};
        d.r1    = head[25:21];
        d.wa    = head[20:16];
        d.we    = 1'b1;
      end
      OP_LW: if (EN_LOADSTORE) begin
        d.aluop = ALU_ADD;
        d.ext   = {{16{head[15]}}, head[15:0]};
        d.r1    = head[25:21];
        d.wa    = head[20:16];
        d.we    = 1'b1;
        d.mr    = 1'b1;
      end else bad = 1'b1;
      OP_SW: if (EN_LOADSTORE) begin
        d.aluop = ALU_ADD;
        d.ext   = {{16{head[15]}}, head[15:0]};
        d.r1    = head[25:21];
        d.r2    = head[20:16];
        d.mw    = 1'b1;
      end else bad = 1'b1;
      default: bad = 1'b1;
    endcase
    if (bad) begin
      d     = DEC_IDLE;
      d.ill = 1'b1;
    end
    if (d.wa == '0) d.we = 1'b0;
  end

  // A load still in the output register cannot forward yet: hold its consumer one cycle.
  assign haz  = id_valid && q.mr && (q.wa != '0) &&
                (((d.r1 != '0) && (d.r1 == q.wa)) || ((d.r2 != '0) && (d.r2 == q.wa)));
  assign adv  = !id_valid || ex_ready;
  assign load = adv && !empty && !haz;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_pc[wptr[AW-1:0]]    <= if_pc;
      mem_instr[wptr[AW-1:0]] <= if_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      id_valid <= 1'b0;
      id_pc    <= '0;
      q        <= DEC_IDLE;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      id_valid <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (load) rptr <= rptr + 1'b1;
      if (adv)  id_valid <= load;
      if (load) begin
        id_pc <= head_pc;
        q     <= d;
      end
    end
  end

  assign id_instr_type = q.itype;
  assign id_aluop      = q.aluop;
  assign id_sa         = q.sa;
  assign id_sa_en      = q.sa_en;
  assign id_ext_imm    = q.ext;
  assign id_raddr1     = q.r1;
  assign id_raddr2     = q.r2;
  assign id_waddr      = q.wa;
  assign id_reg_wr     = q.we;
  assign id_mem_rd     = q.mr;
  assign id_mem_wr     = q.mw;
  assign id_cond       = q.cond;
  assign id_illegal    = q.ill;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: default build plus IQ_DEPTH=2 and an IQ_DEPTH=8 build
// with movn/movz and lw/sw disabled, all fed from one stimulus stream.
module tb_decode_stage;

  localparam logic [3:0] A_AND = 4'd0, A_OR = 4'd1, A_NOR = 4'd3, A_SLL = 4'd4,
                         A_MOV = 4'd7, A_ADD = 4'd8;
  localparam logic [1:0] TR = 2'b01, TI = 2'b10, NC = 2'd0, CNZ = 2'd1, CZ = 2'd2;

  logic clk = 1'b0, rst = 1'b0;
  logic flush = 1'b0, if_valid = 1'b0, ex_ready = 1'b1, lockstep = 1'b1, acc;
  logic [31:0] if_pc = '0, if_instr = '0, pc_n;
  int total = 0, bad = 0, n;

  logic m_rdy, m_v, m_sae, m_we, m_mr, m_mw, m_ill;
  logic [31:0] m_pc, m_ext; logic [1:0] m_ty, m_cond; logic [3:0] m_alu; logic [4:0] m_sa, m_r1, m_r2, m_wa;
  logic a_rdy, a_v, a_sae, a_we, a_mr, a_mw, a_ill;
  logic [31:0] a_pc, a_ext; logic [1:0] a_ty, a_cond; logic [3:0] a_alu; logic [4:0] a_sa, a_r1, a_r2, a_wa;
  logic b_rdy, b_v, b_sae, b_we, b_mr, b_mw, b_ill;
  logic [31:0] b_pc, b_ext; logic [1:0] b_ty, b_cond; logic [3:0] b_alu; logic [4:0] b_sa, b_r1, b_r2, b_wa;
  logic all_rdy, m_iv, o_iv;

  // In lockstep all three builds accept the same instructions; otherwise only the default build is fed.
  assign all_rdy = m_rdy & a_rdy & b_rdy;
  assign m_iv    = if_valid & (lockstep ? all_rdy : 1'b1);
  assign o_iv    = if_valid & lockstep & all_rdy;

  always #5 clk = ~clk;

  decode_stage u_main (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(m_iv), .if_ready(m_rdy), .if_pc(if_pc),
    .if_instr(if_instr), .ex_ready(ex_ready), .id_valid(m_v), .id_pc(m_pc), .id_instr_type(m_ty),
    .id_aluop(m_alu), .id_sa(m_sa), .id_sa_en(m_sae), .id_ext_imm(m_ext), .id_raddr1(m_r1),
    .id_raddr2(m_r2), .id_waddr(m_wa), .id_reg_wr(m_we), .id_mem_rd(m_mr), .id_mem_wr(m_mw),
    .id_cond(m_cond), .id_illegal(m_ill));

  decode_stage #(.IQ_DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(o_iv), .if_ready(a_rdy), .if_pc(if_pc),
    .if_instr(if_instr), .ex_ready(ex_ready), .id_valid(a_v), .id_pc(a_pc), .id_instr_type(a_ty),
    .id_aluop(a_alu), .id_sa(a_sa), .id_sa_en(a_sae), .id_ext_imm(a_ext), .id_raddr1(a_r1),
    .id_raddr2(a_r2), .id_waddr(a_wa), .id_reg_wr(a_we), .id_mem_rd(a_mr), .id_mem_wr(a_mw),
    .id_cond(a_cond), .id_illegal(a_ill));

  decode_stage #(.IQ_DEPTH(8), .EN_MOVCOND(1'b0), .EN_LOADSTORE(1'b0)) u_d8 (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(o_iv), .if_ready(b_rdy), .if_pc(if_pc),
    .if_instr(if_instr), .ex_ready(ex_ready), .id_valid(b_v), .id_pc(b_pc), .id_instr_type(b_ty),
    .id_aluop(b_alu), .id_sa(b_sa), .id_sa_en(b_sae), .id_ext_imm(b_ext), .id_raddr1(b_r1),
    .id_raddr2(b_r2), .id_waddr(b_wa), .id_reg_wr(b_we), .id_mem_rd(b_mr), .id_mem_wr(b_mw),
    .id_cond(b_cond), .id_illegal(b_ill));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ori_k(input int k);
    return {6'h0D, 5'd0, 5'(k + 1), 16'(k)};
  endfunction

  task automatic offer(input logic [31:0] pc, input logic [31:0] ins);
    if_pc = pc; if_instr = ins; if_valid = 1'b1;
    @(posedge clk); #1;
    if_valid = 1'b0;
  endtask

  task automatic decode_one(input logic [31:0] pc, input logic [31:0] ins);
    offer(pc, ins);
    @(posedge clk); #1;
  endtask

  task automatic vec(input string t, input logic [31:0] ins, input logic [1:0] ty, input logic [3:0] alu,
                     input logic [31:0] ext, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] wa,
                     input logic we, input logic mr, input logic mw, input logic [1:0] cnd, input logic ill,
                     input logic [4:0] sa, input logic sae, input logic dis);
    pc_n = pc_n + 32'd4;
    decode_one(pc_n, ins);
    chk({t, ".valid"}, m_v, 1);     chk({t, ".pc"}, m_pc, pc_n);
    chk({t, ".type"}, m_ty, ty);    chk({t, ".aluop"}, m_alu, alu);
    chk({t, ".ext"}, m_ext, ext);   chk({t, ".raddr1"}, m_r1, r1);
    chk({t, ".raddr2"}, m_r2, r2);  chk({t, ".waddr"}, m_wa, wa);
    chk({t, ".reg_wr"}, m_we, we);  chk({t, ".mem_rd"}, m_mr, mr);
    chk({t, ".mem_wr"}, m_mw, mw);  chk({t, ".cond"}, m_cond, cnd);
    chk({t, ".illegal"}, m_ill, ill); chk({t, ".sa"}, m_sa, sa);
    chk({t, ".sa_en"}, m_sae, sae);
    chk({t, ".d2_valid"}, a_v, 1);  chk({t, ".d2_pc"}, a_pc, pc_n);
    chk({t, ".d2_illegal"}, a_ill, ill);
    chk({t, ".d8_valid"}, b_v, 1);  chk({t, ".d8_pc"}, b_pc, pc_n);
    chk({t, ".d8_illegal"}, b_ill, ill | dis);
    chk({t, ".d8_mem_rd"}, b_mr, mr & ~dis);
    chk({t, ".d8_reg_wr"}, b_we, we & ~dis);
  endtask

  task automatic pair(input string t, input logic [31:0] i0, input logic [31:0] i1, input logic bub);
    if_pc = 32'h300; if_instr = i0; if_valid = 1'b1;
    @(posedge clk); #1;
    if_pc = 32'h304; if_instr = i1;
    @(posedge clk); #1;
    if_valid = 1'b0;
    chk({t, ".load_v"}, m_v, 1); chk({t, ".load_pc"}, m_pc, 32'h300);
    @(posedge clk); #1;
    chk({t, ".slot1_v"}, m_v, !bub);
    if (!bub) chk({t, ".slot1_pc"}, m_pc, 32'h304);
    @(posedge clk); #1;
    chk({t, ".slot2_v"}, m_v, bub);
    if (bub) chk({t, ".slot2_pc"}, m_pc, 32'h304);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst.valid", m_v, 0);      chk("rst.ready", m_rdy, 1);
    chk("rst.aluop", m_alu, A_OR); chk("rst.type", m_ty, TI);
    chk("rst.cond", m_cond, NC);   chk("rst.pc", m_pc, 0);
    chk("rst.ext", m_ext, 0);      chk("rst.d2_ready", a_rdy, 1);
    chk("rst.d8_ready", b_rdy, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    pc_n = 32'h1FC;
    //  tag       instr         type alu    ext           r1 r2 wa  we mr mw cond ill sa sae dis
    vec("addiu", 32'h2422FFFC, TI, A_ADD, 32'hFFFFFFFC, 1, 0, 2,  1, 0, 0, NC,  0, 0, 0, 0);
    vec("lui",   32'h3C031234, TI, A_OR,  32'h12340000, 0, 0, 3,  1, 0, 0, NC,  0, 0, 0, 0);
    vec("sw",    32'hAC240008, TI, A_ADD, 32'h00000008, 1, 4, 0,  0, 0, 1, NC,  0, 0, 0, 1);
    vec("movz",  32'h00A6380A, TR, A_MOV, 32'h0,        5, 6, 7,  1, 0, 0, CZ,  0, 0, 0, 1);
    vec("op3f",  32'hFC000000, TI, A_OR,  32'h0,        0, 0, 0,  0, 0, 0, NC,  1, 0, 0, 0);
    vec("lw",    32'h8C480010, TI, A_ADD, 32'h00000010, 2, 0, 8,  1, 1, 0, NC,  0, 0, 0, 1);
    vec("movn",  32'h0022480B, TR, A_MOV, 32'h0,        1, 2, 9,  1, 0, 0, CNZ, 0, 0, 0, 1);
    vec("sll",   32'h00035140, TR, A_SLL, 32'h0,        0, 3, 10, 1, 0, 0, NC,  0, 5, 1, 0);
    vec("nor",   32'h00225827, TR, A_NOR, 32'h0,        1, 2, 11, 1, 0, 0, NC,  0, 0, 0, 0);
    vec("andi0", 32'h30208000, TI, A_AND, 32'h00008000, 1, 0, 0,  0, 0, 0, NC,  0, 0, 0, 0);
    vec("addu",  32'h00226021, TR, A_ADD, 32'h0,        1, 2, 12, 1, 0, 0, NC,  0, 0, 0, 0);
    vec("fn3f",  32'h0000003F, TI, A_OR,  32'h0,        0, 0, 0,  0, 0, 0, NC,  1, 0, 0, 0);

    lockstep = 1'b0;
    pair("lu_rs",   32'h8C250000, 32'h00A23021, 1'b1);
    pair("lu_rt",   32'h8C250000, 32'h00453021, 1'b1);
    pair("lu_none", 32'h8C250000, 32'h00023021, 1'b0);
    pair("lu_zero", 32'h8C200000, 32'h00003021, 1'b0);

    ex_ready = 1'b0;
    for (int k = 0; k < 5; k++) offer(32'h400 + 32'(4 * k), ori_k(k));
    chk("bp.full", m_rdy, 0); chk("bp.valid", m_v, 1); chk("bp.head", m_pc, 32'h400);
    if_pc = 32'h414; if_instr = ori_k(5); if_valid = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("bp.hold_pc", m_pc, 32'h400); chk("bp.hold_ready", m_rdy, 0);
    end
    ex_ready = 1'b1;
    n = 1;
    for (int c = 0; c < 20 && n < 6; c++) begin
      acc = m_rdy & if_valid;
      @(posedge clk); #1;
      if (acc) if_valid = 1'b0;
      if (m_v) begin
        chk("bp.order", m_pc, 32'h400 + 32'(4 * n));
        n++;
      end
    end
    chk("bp.count", n, 6);
    if_valid = 1'b0;
    @(posedge clk); #1;

    ex_ready = 1'b0;
    for (int k = 0; k < 4; k++) offer(32'h500 + 32'(4 * k), ori_k(k));
    chk("fl.pre_valid", m_v, 1); chk("fl.pre_pc", m_pc, 32'h500);
    flush = 1'b1; if_pc = 32'h600; if_instr = ori_k(9); if_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; if_valid = 1'b0;
    chk("fl.valid", m_v, 0); chk("fl.ready", m_rdy, 1);
    ex_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("fl.empty", m_v, 0);
    end
    decode_one(32'h700, ori_k(2));
    chk("fl.after_valid", m_v, 1); chk("fl.after_pc", m_pc, 32'h700);
    @(posedge clk); #1;

    ex_ready = 1'b0;
    for (int k = 0; k < 5; k++) offer(32'h800 + 32'(4 * k), ori_k(k));
    chk("rs.pre_ready", m_rdy, 0); chk("rs.pre_valid", m_v, 1);
    #2 rst = 1'b1;
    #1;
    chk("rs.valid", m_v, 0);      chk("rs.ready", m_rdy, 1);
    chk("rs.pc", m_pc, 0);        chk("rs.aluop", m_alu, A_OR);
    chk("rs.type", m_ty, TI);
    rst = 1'b0; ex_ready = 1'b1;
    decode_one(32'h100, 32'h342100FF);
    chk("ori.valid", m_v, 1);      chk("ori.pc", m_pc, 32'h100);
    chk("ori.ext", m_ext, 32'hFF); chk("ori.aluop", m_alu, A_OR);
    chk("ori.waddr", m_wa, 1);     chk("ori.raddr1", m_r1, 1);
    chk("ori.reg_wr", m_we, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
